usb_tx_pkt_gen: RTL and testbench

USB_TX_PKT_GEN -- requirements
Module: usb_tx_pkt_gen

---
 rtl/usb_tx_pkt_gen.sv | 256 +++++++++++++++++++++++++
 tb/tb_usb_tx_pkt_gen.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_pkt_gen.sv
// ---------------------------------------------------------------------------
// usb_tx_pkt_gen
//
// Generates one USB-style transmit packet per request. The payload is an
// incrementing byte sequence that starts at a caller-supplied seed. It is
// optionally followed by the USB CRC16 of the payload, sent low byte first.
// Bytes leave on a valid/ready beat interface.
//
// State table
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | waiting for send_data; outputs idle
//   S_DATA   | presenting payload beats seed, seed+1, ...
//   S_CRC_LO | presenting CRC16 bits [7:0]
//   S_CRC_HI | presenting CRC16 bits [15:8] (final beat)
//
// Parameters
//   LEN_W   width of the payload length field and of the beat counter
//   HIST_W  depth of the transfer-history shift register (>= 2)
//   CRC_EN  1 = append the 2-byte CRC16 after the payload, 0 = payload only
//
// Ports
//   clk        clock; all state changes on the rising edge
//   reset      synchronous, active-low reset
//   send_data  starts one packet; only looked at in S_IDLE
//   pkt_len    payload byte count, captured with send_data
//   seed       first payload byte, captured with send_data
//   abort      drops the packet in flight and returns to S_IDLE
//   tx_ready   sink ready; a beat moves when tx_valid and tx_ready are high
//   tx_valid   tx_data/tx_last are valid
//   tx_data    current byte
//   tx_last    marks the final beat of the packet
//   busy       high whenever the state is not S_IDLE
//   done       one-cycle pulse after the tx_last beat is accepted
//   hist       per-cycle transfer history; bit 0 is the newest
// ---------------------------------------------------------------------------
module usb_tx_pkt_gen #(
    parameter int LEN_W  = 10,
    parameter int HIST_W = 10,
    parameter bit CRC_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              send_data,
    input  logic [LEN_W-1:0]  pkt_len,
    input  logic [7:0]        seed,
    input  logic              abort,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_last,
    output logic              busy,
    output logic              done,
    output logic [HIST_W-1:0] hist
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_CRC_LO = 2'd2,
        S_CRC_HI = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        crc_q, crc_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_last_q, tx_last_d;
    logic               done_q, done_d;
    logic [HIST_W-1:0]  hist_q, hist_d;

    logic               beat_acc;
    logic               start_req;
    logic               len_zero;
    logic               last_payload;
    logic               next_is_last;
    logic [15:0]        crc_next;

    // Reflected USB CRC16 (poly 0x8005 -> 0xA001), processed LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                               input logic [7:0]  data_in);
        logic [15:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data_in[i]) begin
                c = (c >> 1) ^ 16'hA001;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    assign beat_acc     = tx_valid_q & tx_ready;
    assign start_req    = send_data & ~abort;
    assign len_zero     = (pkt_len == '0);
    assign last_payload = (cnt_q == (len_q - LEN_W'(1)));
    // Only used while more payload remains, so len_q >= cnt_q + 2 here.
    assign next_is_last = ((cnt_q + LEN_W'(1)) == (len_q - LEN_W'(1)));
    // The CRC only ever absorbs the byte currently on the bus.
    assign crc_next     = crc16_byte(crc_q, tx_data_q);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            crc_q      <= 16'hFFFF;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_last_q  <= 1'b0;
            done_q     <= 1'b0;
            hist_q     <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            crc_q      <= crc_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_last_q  <= tx_last_d;
            done_q     <= done_d;
            hist_q     <= hist_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                // A zero-length request without CRC has nothing to send.
                if (start_req) begin
                    if (!len_zero) begin
                        state_d = S_DATA;
                    end else if (CRC_EN) begin
                        state_d = S_CRC_LO;
                    end
                end
            end
            S_DATA: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (beat_acc && last_payload) begin
                    state_d = CRC_EN ? S_CRC_LO : S_IDLE;
                end
            end
            S_CRC_LO: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (beat_acc) begin
                    state_d = S_CRC_HI;
                end
            end
            S_CRC_HI: begin
                if (abort || beat_acc) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output / datapath logic (everything lands in registers)
    // -----------------------------------------------------------------------
    always_comb begin
        len_d      = len_q;
        cnt_d      = cnt_q;
        crc_d      = crc_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        tx_last_d  = tx_last_q;
        done_d     = 1'b0;
        hist_d     = {hist_q[HIST_W-2:0], beat_acc};

        case (state_q)
            S_IDLE: begin
                if (start_req && (!len_zero || CRC_EN)) begin
                    len_d      = pkt_len;
                    cnt_d      = '0;
                    crc_d      = 16'hFFFF;
                    tx_valid_d = 1'b1;
                    if (!len_zero) begin
                        tx_data_d = seed;
                        tx_last_d = !CRC_EN && (pkt_len == LEN_W'(1));
                    end else begin
                        // Empty payload: CRC is ~0xFFFF, so the low byte is 0.
                        tx_data_d = 8'h00;
                        tx_last_d = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (abort) begin
                    tx_valid_d = 1'b0;
                    tx_last_d  = 1'b0;
                end else if (beat_acc) begin
                    crc_d = crc_next;
                    cnt_d = cnt_q + LEN_W'(1);
                    if (last_payload) begin
                        if (CRC_EN) begin
                            tx_data_d = ~crc_next[7:0];
                            tx_last_d = 1'b0;
                        end else begin
                            tx_valid_d = 1'b0;
                            tx_last_d  = 1'b0;
                            done_d     = 1'b1;
                        end
                    end else begin
                        tx_data_d = tx_data_q + 8'd1;
                        tx_last_d = !CRC_EN && next_is_last;
                    end
                end
            end
            S_CRC_LO: begin
                if (abort) begin
                    tx_valid_d = 1'b0;
                    tx_last_d  = 1'b0;
                end else if (beat_acc) begin
                    tx_data_d = ~crc_q[15:8];
                    tx_last_d = 1'b1;
                end
            end
            S_CRC_HI: begin
                if (abort) begin
                    tx_valid_d = 1'b0;
                    tx_last_d  = 1'b0;
                end else if (beat_acc) begin
                    tx_valid_d = 1'b0;
                    tx_last_d  = 1'b0;
                    done_d     = 1'b1;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                tx_last_d  = 1'b0;
            end
        endcase
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign tx_last  = tx_last_q;
    assign done     = done_q;
    assign hist     = hist_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_usb_tx_pkt_gen.sv
module tb_usb_tx_pkt_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        send_data;
    logic [9:0]  pkt_len;
    logic [7:0]  seed;
    logic        abort;
    logic        tx_ready;

    // CRC-enabled instance
    logic        v_c, l_c, b_c, dn_c;
    logic [7:0]  d_c;
    logic [9:0]  h_c;
    // payload-only instance
    logic        v_r, l_r, b_r, dn_r;
    logic [7:0]  d_r;
    logic [9:0]  h_r;

    usb_tx_pkt_gen #(.LEN_W(10), .HIST_W(10), .CRC_EN(1'b1)) u_crc (
        .clk(clk), .reset(reset), .send_data(send_data), .pkt_len(pkt_len),
        .seed(seed), .abort(abort), .tx_ready(tx_ready),
        .tx_valid(v_c), .tx_data(d_c), .tx_last(l_c), .busy(b_c),
        .done(dn_c), .hist(h_c)
    );

    usb_tx_pkt_gen #(.LEN_W(10), .HIST_W(10), .CRC_EN(1'b0)) u_raw (
        .clk(clk), .reset(reset), .send_data(send_data), .pkt_len(pkt_len),
        .seed(seed), .abort(abort), .tx_ready(tx_ready),
        .tx_valid(v_r), .tx_data(d_r), .tx_last(l_r), .busy(b_r),
        .done(dn_r), .hist(h_r)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct {
        logic [7:0] seed;
        int         len;
        int         mode;       // 0 ready high, 1 toggle, 2 random
        int         beats_crc;
        int         beats_raw;
    } vec_t;

    beat_t q_crc[$];
    beat_t q_raw[$];

    int vectors = 0;
    int miscompares = 0;
    int rdy_mode = 0;           // 3 hold low, 4 driven by hand
    int nb[2];
    bit ef[2];
    bit stall[2];
    logic [7:0] hd[2];
    bit hl[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_crc(input logic [7:0] s, input int n);
        logic [15:0] r;
        logic [7:0]  b;
        logic        fb;
        r = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            b = s + 8'(k);
            for (int i = 0; i < 8; i++) begin
                fb = r[0] ^ b[i];
                r  = {1'b0, r[15:1]};
                if (fb) r = r ^ 16'hA001;
            end
        end
        return ~r;
    endfunction

    task automatic push_model(input logic [7:0] s, input int n);
        beat_t e;
        logic [15:0] c;
        for (int k = 0; k < n; k++) begin
            e.data = s + 8'(k);
            e.last = 1'b0;
            q_crc.push_back(e);
            e.last = (k == n - 1);
            q_raw.push_back(e);
        end
        c = model_crc(s, n);
        e.data = c[7:0];  e.last = 1'b0; q_crc.push_back(e);
        e.data = c[15:8]; e.last = 1'b1; q_crc.push_back(e);
    endtask

    // Scoreboard monitor, one per instance, sampled on the falling edge.
    task automatic mon(input int id, input logic v, input logic [7:0] d,
                       input logic l, input logic dn);
        beat_t e;
        int    sz;
        if (!reset) begin
            ef[id]    = 1'b0;
            stall[id] = 1'b0;
            return;
        end
        chk($sformatf("done_%0d", id), {31'd0, dn}, {31'd0, ef[id]});
        ef[id] = 1'b0;
        if (stall[id]) begin
            chk($sformatf("stall_valid_%0d", id), {31'd0, v}, 32'd1);
            chk($sformatf("stall_data_%0d", id), {24'd0, d}, {24'd0, hd[id]});
            chk($sformatf("stall_last_%0d", id), {31'd0, l}, {31'd0, hl[id]});
        end
        stall[id] = 1'b0;
        if (v && tx_ready) begin
            nb[id]++;
            sz = (id == 1) ? q_crc.size() : q_raw.size();
            if (sz == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL extra_beat_%0d: got beat 0x%0h with nothing expected at %0t", id, d, $time);
            end else begin
                e = (id == 1) ? q_crc.pop_front() : q_raw.pop_front();
                chk($sformatf("beat_data_%0d", id), {24'd0, d}, {24'd0, e.data});
                chk($sformatf("beat_last_%0d", id), {31'd0, l}, {31'd0, e.last});
                if (l) ef[id] = 1'b1;
            end
        end else if (v && !abort) begin
            stall[id] = 1'b1;
            hd[id]    = d;
            hl[id]    = l;
        end
    endtask

    always @(negedge clk) begin
        mon(1, v_c, d_c, l_c, dn_c);
        mon(0, v_r, d_r, l_r, dn_r);
    end

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: tx_ready = 1'b1;
                1: tx_ready = ~tx_ready;
                2: tx_ready = 1'($urandom_range(0, 1));
                3: tx_ready = 1'b0;
                default: ;
            endcase
        end
    end

    // Called just after a rising edge. Optionally pushes model expectations and
    // pokes send_data/pkt_len/seed while the packet is in flight.
    task automatic send(input logic [7:0] s, input int n, input bit use_model, input bit glitch);
        nb[0] = 0;
        nb[1] = 0;
        if (use_model) push_model(s, n);
        send_data = 1'b1;
        pkt_len   = 10'(n);
        seed      = s;
        @(posedge clk);
        #1;
        send_data = 1'b0;
        pkt_len   = 10'($urandom_range(1, 1023));
        seed      = 8'($urandom);
        chk("latency_crc", {31'd0, v_c}, 32'd1);
        chk("latency_raw", {31'd0, v_r}, {31'd0, (n != 0)});
        if (glitch && n != 0) begin
            send_data = 1'b1;
            @(posedge clk);
            #1;
            send_data = 1'b0;
            pkt_len   = 10'($urandom_range(1, 1023));
            seed      = 8'($urandom);
        end
    endtask

    task automatic wait_idle(input int budget, input int exp_c, input int exp_r);
        int n;
        n = 0;
        while (!(q_crc.size() == 0 && q_raw.size() == 0 && !b_c && !b_r) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= budget) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle: timed out after %0d cycles, %0d/%0d beats left", budget, q_crc.size(), q_raw.size());
        end
        @(posedge clk);
        #1;
        chk("beats_crc", 32'(nb[1]), 32'(exp_c));
        chk("beats_raw", 32'(nb[0]), 32'(exp_r));
    endtask

    vec_t tbl[7];

    initial begin
        beat_t e;
        int    n;

        tbl[0] = '{8'h31,  9, 1, 11,  9};
        tbl[1] = '{8'h00,  0, 0,  2,  0};
        tbl[2] = '{8'hFE,  4, 0,  6,  4};
        tbl[3] = '{8'hA5,  1, 2,  3,  1};
        tbl[4] = '{8'h7F,  3, 2,  5,  3};
        tbl[5] = '{8'hF0, 20, 1, 22, 20};
        tbl[6] = '{8'h55,  2, 0,  4,  2};

        reset     = 1'b0;
        send_data = 1'b0;
        pkt_len   = '0;
        seed      = '0;
        abort     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, v_c}, 32'd0);
        chk("rst_data",  {24'd0, d_c}, 32'd0);
        chk("rst_last",  {31'd0, l_c}, 32'd0);
        chk("rst_busy",  {31'd0, b_c}, 32'd0);
        chk("rst_done",  {31'd0, dn_c}, 32'd0);
        chk("rst_hist",  {22'd0, h_c}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // "123456789" with ready held high; known CRC 0xB4C8.
        rdy_mode = 0;
        for (int k = 0; k < 9; k++) begin
            e.data = 8'h31 + 8'(k);
            e.last = 1'b0;
            q_crc.push_back(e);
            e.last = (k == 8);
            q_raw.push_back(e);
        end
        e = '{8'hC8, 1'b0}; q_crc.push_back(e);
        e = '{8'hB4, 1'b1}; q_crc.push_back(e);
        send(8'h31, 9, 1'b0, 1'b1);
        n = 0;
        while (!dn_c && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("known_done_seen", {31'd0, dn_c}, 32'd1);
        chk("known_hist", {22'd0, h_c}, 32'h3FF);
        wait_idle(50, 11, 9);

        // Table of packets under different sink behaviours.
        for (int i = 0; i < 7; i++) begin
            rdy_mode = tbl[i].mode;
            @(posedge clk);
            #1;
            send(tbl[i].seed, tbl[i].len, 1'b1, 1'b1);
            wait_idle(300, tbl[i].beats_crc, tbl[i].beats_raw);
        end

        // Abort after three accepted beats.
        rdy_mode = 4;
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        send(8'h40, 8, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        tx_ready = 1'b0;
        abort    = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_valid_c", {31'd0, v_c}, 32'd0);
        chk("abort_last_c",  {31'd0, l_c}, 32'd0);
        chk("abort_busy_c",  {31'd0, b_c}, 32'd0);
        chk("abort_valid_r", {31'd0, v_r}, 32'd0);
        chk("abort_busy_r",  {31'd0, b_r}, 32'd0);
        chk("abort_beats_c", 32'(nb[1]), 32'd3);
        chk("abort_beats_r", 32'(nb[0]), 32'd3);
        q_crc.delete();
        q_raw.delete();
        repeat (3) @(posedge clk);
        #1;
        tx_ready = 1'b1;
        rdy_mode = 0;
        send(8'h12, 5, 1'b1, 1'b1);
        wait_idle(100, 7, 5);

        // Abort together with a request in IDLE must be ignored.
        abort     = 1'b1;
        send_data = 1'b1;
        pkt_len   = 10'd3;
        @(posedge clk);
        #1;
        abort     = 1'b0;
        send_data = 1'b0;
        chk("abort_req_busy_c",  {31'd0, b_c}, 32'd0);
        chk("abort_req_valid_c", {31'd0, v_c}, 32'd0);

        // Reset held low for two cycles mid-packet, then a request on release.
        send(8'h10, 8, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_valid", {31'd0, v_c}, 32'd0);
        chk("mid_rst_data",  {24'd0, d_c}, 32'd0);
        chk("mid_rst_last",  {31'd0, l_c}, 32'd0);
        chk("mid_rst_busy",  {31'd0, b_c}, 32'd0);
        chk("mid_rst_done",  {31'd0, dn_c}, 32'd0);
        chk("mid_rst_hist",  {22'd0, h_c}, 32'd0);
        chk("mid_rst_hist_r", {22'd0, h_r}, 32'd0);
        q_crc.delete();
        q_raw.delete();
        reset = 1'b1;
        send(8'hC0, 5, 1'b1, 1'b0);
        wait_idle(100, 7, 5);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
        $fatal(1, "watchdog");
    end

endmodule
